tl_instruction_decode: RTL and testbench
========================================

# tl_instruction_decode

Second stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch. Consumes the IF/ID word (instruction, PC+1), reads the 32×32 register file, decodes control, sign/zero-extends immediates, and detects load-use hazards. It resolves J/JAL/JR/JALR jumps back to fetch and registers everything into the ID/EX pipeline register.

## Interface
- LEN, 32, datapath width
- NREG, 32, register file depth (5-bit addresses)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_instruccion  in  LEN  IF/ID instruction
- i_pc_plus1  in  LEN  IF/ID PC+1 (word-addressed PC)
- i_flush  in  1  branch taken in EX (same signal as fetch PCSrc)
- i_wb_write  in  1  write-back enable
- i_wb_addr  in  5  write-back register
- i_wb_data  in  LEN  write-back data
- o_flag_stall  out  1  load-use stall to fetch (combinational)
- o_flag_jump  out  1  jump taken to fetch (combinational)
- o_dir_jump  out  LEN  jump target to fetch (combinational)
- o_pc_plus1, o_rs_data, o_rt_data, o_imm_ext  out  LEN each  ID/EX data
- o_rs, o_rt, o_rd, o_shamt  out  5 each  ID/EX fields
- o_funct  out  6  ID/EX funct
- o_alu_op  out  3  000 add, 001 sub, 010 R-type(funct), 011 and, 100 or, 101 xor, 110 lui, 111 slt
- o_reg_dst  out  2  00 rt, 01 rd, 10 r31
- o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write, o_beq, o_bne, o_link, o_halt  out  1 each  ID/EX control

## Operation
- Register file: 32 entries, r0 reads 0, writes to r0 ignored. Write on rising edge when i_wb_write. Combinational reads with bypass: read addr == i_wb_addr, nonzero, i_wb_write → i_wb_data returned.
- Decode (opcode/funct, standard MIPS): R-type (reg_dst=01, reg_write, alu_op=010); JR funct 08 (no write); JALR funct 09 (reg_dst=01, reg_write, link); LW 23 / LB 20 / LH 21 / LBU 24 / LHU 25 (alu_src, mem_read, mem_to_reg, reg_write, add); SW 2B / SB 28 / SH 29 (alu_src, mem_write, add); ADDI 08 (add), SLTI 0A (slt), ANDI 0C / ORI 0D / XORI 0E (zero-extend imm), LUI 0F; BEQ 04 / BNE 05 (sub, beq/bne); J 02; JAL 03 (reg_dst=10, reg_write, link). Instruction 0xFFFFFFFF → o_halt=1, all other control 0. Any other opcode → all control 0 (NOP).
- o_imm_ext: zero-extended for ANDI/ORI/XORI, else sign-extended imm[15:0].
- Jump target: J/JAL → {i_pc_plus1[31:26], instr[25:0]}; JR/JALR → rs read value (after bypass).
- Hazard: stall = o_mem_read && o_rt≠0 && (o_rt==instr rs || o_rt==instr rt) (uses registered ID/EX fields).
- o_flag_jump = jump decoded && !stall && !i_flush.
- ID/EX update priority: !i_rst → all zero; else i_flush or stall → bubble (entire register zero); else capture decoded values.

## Timing
- ID/EX register and reset sampling on falling edge of i_clk, matching IF/ID; register file writes and reset on rising edge.
- Reset: every ID/EX output 0; all registers 0; o_flag_stall/o_flag_jump follow combinationally from zeroed state (0 while IF/ID holds 0).
- Latency: one falling edge from IF/ID to ID/EX.
- Stall: one bubble inserted; IF/ID holds, next edge same instruction decodes with stall cleared (loaded o_mem_read now 0).
- Write-back and read of same register in same half cycle: bypass returns new value.
- i_flush and stall together: bubble; o_flag_jump suppressed.
- Reset mid-stall: outputs zero at next falling edge, stall deasserts.

## Test plan
- Reset: i_rst=0 two cycles → all ID/EX outputs 0; read r5 returns 0.
- Bypass: wb r3=0x1234 while decoding ADDU r1,r3,r0 → o_rs_data=0x1234, o_reg_dst=01, o_alu_op=010, o_reg_write=1.
- Load-use: LW r2,4(r0) then ADD r4,r2,r2 → o_flag_stall=1 one cycle, bubble (all zero) in ID/EX, ADD captured next edge.
- Jumps: J 0x0000010 at pc_plus1=0x5 → o_flag_jump=1, o_dir_jump=0x10; JAL → o_reg_dst=10, o_link=1; JR r7 (r7=0x40) → o_dir_jump=0x40.
- Immediates: ORI r1,r0,0x8000 → o_imm_ext=0x00008000; ADDI same imm → 0xFFFF8000.
- Flush/halt: i_flush=1 during BEQ → bubble; 0xFFFFFFFF → o_halt=1, reg_write=0; write to r0 ignored.

Source files
------------

// File: rtl/tl_instruction_decode.sv
// ID stage of the 5-stage MIPS pipeline.
// Register file with write-back bypass, control decode, immediate extension,
// load-use hazard detection, jump resolution, and the ID/EX pipeline register.
module tl_instruction_decode #(
  parameter int unsigned LEN  = 32,
  parameter int unsigned NREG = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [LEN-1:0] i_instruccion,
  input  logic [LEN-1:0] i_pc_plus1,
  input  logic           i_flush,
  input  logic           i_wb_write,
  input  logic [4:0]     i_wb_addr,
  input  logic [LEN-1:0] i_wb_data,
  output logic           o_flag_stall,
  output logic           o_flag_jump,
  output logic [LEN-1:0] o_dir_jump,
  output logic [LEN-1:0] o_pc_plus1,
  output logic [LEN-1:0] o_rs_data,
  output logic [LEN-1:0] o_rt_data,
  output logic [LEN-1:0] o_imm_ext,
  output logic [4:0]     o_rs,
  output logic [4:0]     o_rt,
  output logic [4:0]     o_rd,
  output logic [4:0]     o_shamt,
  output logic [5:0]     o_funct,
  output logic [2:0]     o_alu_op,
  output logic [1:0]     o_reg_dst,
  output logic           o_alu_src,
  output logic           o_mem_read,
  output logic           o_mem_write,
  output logic           o_mem_to_reg,
  output logic           o_reg_write,
  output logic           o_beq,
  output logic           o_bne,
  output logic           o_link,
  output logic           o_halt
);

  localparam int unsigned IMMW = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  logic [LEN-1:0] r_regs [NREG];

  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_shamt;
  logic [5:0]      w_funct;
  logic [IMMW-1:0] w_imm;
  logic [LEN-1:0]  w_rs_data;
  logic [LEN-1:0]  w_rt_data;
  logic [LEN-1:0]  w_imm_ext;
  logic            w_halt;
  logic            w_zext;
  logic            w_jump;
  logic            w_jtype;
  logic [2:0]      w_alu_op;
  logic [1:0]      w_reg_dst;
  logic            w_alu_src;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_mem_to_reg;
  logic            w_reg_write;
  logic            w_beq;
  logic            w_bne;
  logic            w_link;

  assign w_op    = i_instruccion[31:26];
  assign w_rs    = i_instruccion[25:21];
  assign w_rt    = i_instruccion[20:16];
  assign w_rd    = i_instruccion[15:11];
  assign w_shamt = i_instruccion[10:6];
  assign w_funct = i_instruccion[5:0];
  assign w_imm   = i_instruccion[15:0];
  assign w_halt  = (i_instruccion == '1);

  // Register file write port; r0 is never written so it always reads zero
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (i_wb_write && (i_wb_addr != 5'd0)) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Read ports with same-cycle write-back bypass
  always_comb begin
    w_rs_data = '0;
    w_rt_data = '0;
    if (w_rs != 5'd0) w_rs_data = (i_wb_write && (i_wb_addr == w_rs)) ? i_wb_data : r_regs[w_rs];
    if (w_rt != 5'd0) w_rt_data = (i_wb_write && (i_wb_addr == w_rt)) ? i_wb_data : r_regs[w_rt];
  end

  // Control decode from opcode/funct
  always_comb begin
    w_alu_op     = ALU_ADD;
    w_reg_dst    = DST_RT;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_link       = 1'b0;
    w_jump       = 1'b0;
    w_jtype      = 1'b0;
    w_zext       = 1'b0;
    if (!w_halt) begin
      case (w_op)
        OP_RTYPE: begin
          if (w_funct == FN_JR) begin
            w_jump = 1'b1;
          end else begin
            w_reg_dst   = DST_RD;
            w_reg_write = 1'b1;
            w_alu_op    = ALU_R;
            if (w_funct == FN_JALR) begin
              w_link = 1'b1;
              w_jump = 1'b1;
            end
          end
        end
        OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU: begin
          w_alu_src    = 1'b1;
          w_mem_read   = 1'b1;
          w_mem_to_reg = 1'b1;
          w_reg_write  = 1'b1;
        end
        OP_SW, OP_SB, OP_SH: begin
          w_alu_src   = 1'b1;
          w_mem_write = 1'b1;
        end
        OP_ADDI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
        OP_SLTI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_SLT; end
        OP_ANDI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_AND; w_zext = 1'b1; end
        OP_ORI:  begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_OR;  w_zext = 1'b1; end
        OP_XORI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_XOR; w_zext = 1'b1; end
        OP_LUI:  begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = ALU_LUI; end
        OP_BEQ:  begin w_alu_op = ALU_SUB; w_beq = 1'b1; end
        OP_BNE:  begin w_alu_op = ALU_SUB; w_bne = 1'b1; end
        OP_J:    begin w_jump = 1'b1; w_jtype = 1'b1; end
        OP_JAL: begin
          w_jump      = 1'b1;
          w_jtype     = 1'b1;
          w_reg_dst   = DST_R31;
          w_reg_write = 1'b1;
          w_link      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_imm_ext = w_zext ? LEN'(w_imm) : {{(LEN-IMMW){w_imm[IMMW-1]}}, w_imm};

  // Load-use hazard against the instruction currently held in ID/EX
  assign o_flag_stall = o_mem_read && (o_rt != 5'd0) && ((o_rt == w_rs) || (o_rt == w_rt));
  assign o_flag_jump  = w_jump && !o_flag_stall && !i_flush;
  assign o_dir_jump   = w_jtype ? {i_pc_plus1[LEN-1:26], i_instruccion[25:0]} : w_rs_data;

  // ID/EX pipeline register; flush or stall inserts a fully zeroed bubble
  always_ff @(negedge i_clk) begin
    if (!i_rst || i_flush || o_flag_stall) begin
      o_pc_plus1   <= '0;
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imm_ext    <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_shamt      <= '0;
      o_funct      <= '0;
      o_alu_op     <= '0;
      o_reg_dst    <= '0;
      o_alu_src    <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_beq        <= 1'b0;
      o_bne        <= 1'b0;
      o_link       <= 1'b0;
      o_halt       <= 1'b0;
    end else begin
      o_pc_plus1   <= i_pc_plus1;
      o_rs_data    <= w_rs_data;
      o_rt_data    <= w_rt_data;
      o_imm_ext    <= w_imm_ext;
      o_rs         <= w_rs;
      o_rt         <= w_rt;
      o_rd         <= w_rd;
      o_shamt      <= w_shamt;
      o_funct      <= w_funct;
      o_alu_op     <= w_alu_op;
      o_reg_dst    <= w_reg_dst;
      o_alu_src    <= w_alu_src;
      o_mem_read   <= w_mem_read;
      o_mem_write  <= w_mem_write;
      o_mem_to_reg <= w_mem_to_reg;
      o_reg_write  <= w_reg_write;
      o_beq        <= w_beq;
      o_bne        <= w_bne;
      o_link       <= w_link;
      o_halt       <= w_halt;
    end
  end

endmodule

// File: tb/tb_tl_instruction_decode.sv
// Testbench for tl_instruction_decode: directed scenarios plus randomized
// instruction streams checked against a mnemonic-level reference model.
module tb_tl_instruction_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [2:0]  aluop;
    logic [1:0]  regdst;
    logic        alu_src;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        beq;
    logic        bne;
    logic        link;
    logic        halt;
  } idex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        o_flag_stall, o_flag_jump;
  logic [31:0] o_dir_jump, o_pc_plus1, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct;
  logic [2:0]  o_alu_op;
  logic [1:0]  o_reg_dst;
  logic        o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic        o_beq, o_bne, o_link, o_halt;

  always #5 clk = ~clk;

  tl_instruction_decode dut (
    .i_clk(clk), .i_rst(rst), .i_instruccion(instr), .i_pc_plus1(pc),
    .i_flush(flush), .i_wb_write(wb_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_flag_stall(o_flag_stall), .o_flag_jump(o_flag_jump), .o_dir_jump(o_dir_jump),
    .o_pc_plus1(o_pc_plus1), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_funct(o_funct), .o_alu_op(o_alu_op), .o_reg_dst(o_reg_dst),
    .o_alu_src(o_alu_src), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_beq(o_beq),
    .o_bne(o_bne), .o_link(o_link), .o_halt(o_halt)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs [32];
  idex_t       exp_q, exp_d, obs_q;
  logic        exp_stall, exp_jump, obs_stall, obs_jump;
  logic [31:0] exp_dir, obs_dir;

  assign obs_q = {o_pc_plus1, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_shamt,
                  o_funct, o_alu_op, o_reg_dst, o_alu_src, o_mem_read, o_mem_write,
                  o_mem_to_reg, o_reg_write, o_beq, o_bne, o_link, o_halt};

  // Architectural register read as seen in ID, including write-back forwarding
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_write && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  function automatic bit is_jump(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    return (op == 6'h02) || (op == 6'h03) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
  endfunction

  // What ID/EX should hold for this instruction, by mnemonic class
  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] p);
    idex_t       d;
    logic [5:0]  op;
    logic [15:0] im;
    op = ins[31:26];
    im = ins[15:0];
    d = '0;
    d.pc   = p;
    d.rs   = ins[25:21];
    d.rt   = ins[20:16];
    d.rd   = ins[15:11];
    d.sh   = ins[10:6];
    d.fn   = ins[5:0];
    d.rs_d = model_read(d.rs);
    d.rt_d = model_read(d.rt);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) d.imm = {16'h0000, im};
    else d.imm = 32'($signed(im));
    if (ins == 32'hFFFF_FFFF) begin
      d.halt = 1'b1;
      return d;
    end
    case (op)
      6'h00: if (d.fn != 6'h08) begin
               d.regdst = 2'b01; d.rw = 1'b1; d.aluop = 3'b010; d.link = (d.fn == 6'h09);
             end
      6'h23, 6'h20, 6'h21, 6'h24, 6'h25: begin d.alu_src = 1; d.mr = 1; d.m2r = 1; d.rw = 1; end
      6'h2B, 6'h28, 6'h29: begin d.alu_src = 1; d.mw = 1; end
      6'h08: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b000; end
      6'h0A: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b111; end
      6'h0C: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b011; end
      6'h0D: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b100; end
      6'h0E: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b101; end
      6'h0F: begin d.alu_src = 1; d.rw = 1; d.aluop = 3'b110; end
      6'h04: begin d.aluop = 3'b001; d.beq = 1; end
      6'h05: begin d.aluop = 3'b001; d.bne = 1; end
      6'h03: begin d.regdst = 2'b10; d.rw = 1; d.link = 1; end
      default: ;
    endcase
    return d;
  endfunction

  // One clock: drive after rising edge, sample combinational outputs
  // mid-high-phase, then let the falling edge capture and advance the model.
  task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] p,
                       input logic fl, input logic ww, input logic [4:0] wa,
                       input logic [31:0] wd);
    idex_t dec;
    @(posedge clk); #1;
    rst = r; instr = ins; pc = p; flush = fl; wb_write = ww; wb_addr = wa; wb_data = wd;
    dec       = model_decode(ins, p);
    exp_stall = exp_q.mr && exp_q.rt != 5'd0 && (exp_q.rt == ins[25:21] || exp_q.rt == ins[20:16]);
    exp_jump  = is_jump(ins) && !exp_stall && !fl;
    exp_dir   = (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) ? {p[31:26], ins[25:0]}
                                                             : model_read(ins[25:21]);
    exp_d     = (!r || fl || exp_stall) ? idex_t'(0) : dec;
    #2;
    obs_stall = o_flag_stall;
    obs_jump  = o_flag_jump;
    obs_dir   = o_dir_jump;
    @(negedge clk); #1;
    exp_q = exp_d;
    if (!r) begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    end else if (ww && wa != 5'd0) begin
      regs[wa] = wd;
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_q !== idex_t'(0)) begin errors++; $display("FAIL reset_idex_1 got %h exp 0", obs_q); end
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_q !== idex_t'(0)) begin errors++; $display("FAIL reset_idex_2 got %h exp 0", obs_q); end
    checks++; if (obs_stall !== 1'b0 || obs_jump !== 1'b0) begin
      errors++; $display("FAIL reset_flags got stall=%b jump=%b exp 0 0", obs_stall, obs_jump); end
    // ADDU r1,r5,r0 right after reset: r5 must read 0
    cycle(1'b1, 32'h00A0_0821, 32'h1, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (o_rs_data !== 32'd0) begin errors++; $display("FAIL reset_r5 got %h exp 0", o_rs_data); end
    checks++; if (obs_q !== exp_q) begin errors++; $display("FAIL reset_decode got %h exp %h", obs_q, exp_q); end
  endtask

  task automatic test_bypass();
    // ADDU r1,r3,r0 while write-back delivers r3=0x1234
    cycle(1'b1, 32'h0060_0821, 32'h2, 1'b0, 1'b1, 5'd3, 32'h1234);
    checks++; if (o_rs_data !== 32'h1234) begin errors++; $display("FAIL bypass_rs got %h exp 1234", o_rs_data); end
    checks++; if ({o_reg_dst, o_alu_op, o_reg_write} !== {2'b01, 3'b010, 1'b1}) begin
      errors++; $display("FAIL bypass_ctl got %b_%b_%b exp 01_010_1", o_reg_dst, o_alu_op, o_reg_write); end
    checks++; if (obs_q !== exp_q) begin errors++; $display("FAIL bypass_idex got %h exp %h", obs_q, exp_q); end
  endtask

  task automatic test_load_use();
    cycle(1'b1, 32'h8C02_0004, 32'h3, 1'b0, 1'b0, 5'd0, 32'd0);  // LW r2,4(r0)
    checks++; if (obs_q !== exp_q) begin errors++; $display("FAIL lw_idex got %h exp %h", obs_q, exp_q); end
    cycle(1'b1, 32'h0042_2020, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);  // ADD r4,r2,r2
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b exp 1", obs_stall); end
    checks++; if (obs_q !== idex_t'(0)) begin errors++; $display("FAIL loaduse_bubble got %h exp 0", obs_q); end
    cycle(1'b1, 32'h0042_2020, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL loaduse_release got %b exp 0", obs_stall); end
    checks++; if (o_rd !== 5'd4 || obs_q !== exp_q) begin
      errors++; $display("FAIL loaduse_add got %h exp %h", obs_q, exp_q); end
  endtask

  task automatic test_jumps();
    cycle(1'b1, 32'h0800_0010, 32'h5, 1'b0, 1'b0, 5'd0, 32'd0);  // J 0x10
    checks++; if (obs_jump !== 1'b1 || obs_dir !== 32'h10) begin
      errors++; $display("FAIL j_target got jump=%b dir=%h exp 1 10", obs_jump, obs_dir); end
    cycle(1'b1, 32'h0800_0010, 32'hFC00_0005, 1'b0, 1'b0, 5'd0, 32'd0);  // J keeps PC upper bits
    checks++; if (obs_dir !== 32'hFC00_0010) begin errors++; $display("FAIL j_upper got %h exp fc000010", obs_dir); end
    cycle(1'b1, 32'h0C00_0010, 32'h5, 1'b0, 1'b0, 5'd0, 32'd0);  // JAL
    checks++; if (obs_jump !== 1'b1 || o_reg_dst !== 2'b10 || o_link !== 1'b1 || o_reg_write !== 1'b1) begin
      errors++; $display("FAIL jal_ctl got jump=%b dst=%b link=%b rw=%b exp 1 10 1 1", obs_jump, o_reg_dst, o_link, o_reg_write); end
    cycle(1'b1, 32'd0, 32'h6, 1'b0, 1'b1, 5'd7, 32'h40);          // r7 = 0x40
    cycle(1'b1, 32'h00E0_0008, 32'h7, 1'b0, 1'b0, 5'd0, 32'd0);  // JR r7
    checks++; if (obs_jump !== 1'b1 || obs_dir !== 32'h40) begin
      errors++; $display("FAIL jr_target got jump=%b dir=%h exp 1 40", obs_jump, obs_dir); end
    checks++; if (obs_q !== exp_q || o_reg_write !== 1'b0) begin
      errors++; $display("FAIL jr_idex got %h exp %h", obs_q, exp_q); end
  endtask

  task automatic test_immediates();
    cycle(1'b1, 32'h3401_8000, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);  // ORI r1,r0,0x8000
    checks++; if (o_imm_ext !== 32'h0000_8000) begin errors++; $display("FAIL ori_imm got %h exp 00008000", o_imm_ext); end
    cycle(1'b1, 32'h2001_8000, 32'h9, 1'b0, 1'b0, 5'd0, 32'd0);  // ADDI r1,r0,0x8000
    checks++; if (o_imm_ext !== 32'hFFFF_8000) begin errors++; $display("FAIL addi_imm got %h exp ffff8000", o_imm_ext); end
    checks++; if (obs_q !== exp_q) begin errors++; $display("FAIL addi_idex got %h exp %h", obs_q, exp_q); end
  endtask

  task automatic test_flush_halt();
    cycle(1'b1, 32'h1022_0003, 32'hA, 1'b1, 1'b0, 5'd0, 32'd0);  // BEQ under flush
    checks++; if (obs_q !== idex_t'(0)) begin errors++; $display("FAIL flush_bubble got %h exp 0", obs_q); end
    cycle(1'b1, 32'hFFFF_FFFF, 32'hB, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (o_halt !== 1'b1 || o_reg_write !== 1'b0 || obs_q !== exp_q) begin
      errors++; $display("FAIL halt got %h exp %h", obs_q, exp_q); end
    cycle(1'b1, 32'h0000_0821, 32'hC, 1'b0, 1'b1, 5'd0, 32'hDEAD);  // write r0, read r0
    checks++; if (o_rs_data !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h exp 0", o_rs_data); end
    cycle(1'b1, 32'h0000_0821, 32'hD, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (o_rs_data !== 32'd0) begin errors++; $display("FAIL r0_write got %h exp 0", o_rs_data); end
    // Load-use on a JR that is also flushed: bubble, no jump
    cycle(1'b1, 32'h8C07_0000, 32'hE, 1'b0, 1'b0, 5'd0, 32'd0);  // LW r7,0(r0)
    cycle(1'b1, 32'h00E0_0008, 32'hF, 1'b1, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b1 || obs_jump !== 1'b0 || obs_q !== idex_t'(0)) begin
      errors++; $display("FAIL flush_stall got stall=%b jump=%b idex=%h exp 1 0 0", obs_stall, obs_jump, obs_q); end
  endtask

  task automatic test_reset_mid_stall();
    cycle(1'b1, 32'h8C02_0004, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'h0042_2020, 32'h11, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b1 || obs_q !== idex_t'(0)) begin
      errors++; $display("FAIL rst_stall got stall=%b idex=%h exp 1 0", obs_stall, obs_q); end
    cycle(1'b1, 32'h0042_2020, 32'h11, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_stall !== 1'b0 || obs_q !== exp_q) begin
      errors++; $display("FAIL rst_release got stall=%b idex=%h exp 0 %h", obs_stall, obs_q, exp_q); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    case ($urandom_range(0, 21))
      0, 1, 2: op = 6'h00;
      3:  op = 6'h23;  4:  op = 6'h20;  5:  op = 6'h21;  6:  op = 6'h24;
      7:  op = 6'h25;  8:  op = 6'h2B;  9:  op = 6'h28;  10: op = 6'h29;
      11: op = 6'h08;  12: op = 6'h0A;  13: op = 6'h0C;  14: op = 6'h0D;
      15: op = 6'h0E;  16: op = 6'h0F;  17: op = 6'h04;  18: op = 6'h05;
      19: op = 6'h02;  20: op = 6'h03;
      default: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
    endcase
    if ($urandom_range(0, 24) == 0) return 32'hFFFF_FFFF;
    case ($urandom_range(0, 7))
      0: fn = 6'h08;  1: fn = 6'h09;  2: fn = 6'h00;  3: fn = 6'h2A;
      4: fn = 6'h21;  5: fn = 6'h22;  default: fn = 6'(($urandom));
    endcase
    if (op == 6'h00)
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom), fn};
    if (op == 6'h02 || op == 6'h03) return {op, 26'($urandom)};
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] ins = 32'd0;
    logic [31:0] p   = 32'd0;
    logic        fl;
    logic        held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        ins = rand_instr();
        p   = $urandom();
      end
      fl = ($urandom_range(0, 7) == 0);
      cycle(1'b1, ins, p, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
      held = exp_stall;
      checks++; if (obs_stall !== exp_stall) begin
        errors++; $display("FAIL rand_stall n=%0d ins=%h got %b exp %b", n, ins, obs_stall, exp_stall); end
      checks++; if (obs_jump !== exp_jump) begin
        errors++; $display("FAIL rand_jump n=%0d ins=%h got %b exp %b", n, ins, obs_jump, exp_jump); end
      if (exp_jump) begin
        checks++; if (obs_dir !== exp_dir) begin
          errors++; $display("FAIL rand_dir n=%0d ins=%h got %h exp %h", n, ins, obs_dir, exp_dir); end
      end
      checks++; if (obs_q !== exp_q) begin
        errors++; $display("FAIL rand_idex n=%0d ins=%h got %h exp %h", n, ins, obs_q, exp_q); end
    end
  endtask

  initial begin
    rst = 1'b0; instr = '0; pc = '0; flush = 1'b0;
    wb_write = 1'b0; wb_addr = '0; wb_data = '0;
    exp_q = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    test_reset();
    test_bypass();
    test_load_use();
    test_jumps();
    test_immediates();
    test_flush_halt();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
